uart_led_frame_rx: RTL and testbench
====================================

// Module: uart_led_frame_rx
// PURPOSE
//   UART receive front end for the 24-LED card. Deserialises 8N1 bytes on rx,
//   parses fixed 4-byte frames (sync 0xA5 + 3 pattern bytes) and presents the
//   24-bit LED pattern atomically to the LED output register stage.
//   Sits between the rx pin and the leds register of the top level.
// PARAMETERS
//   CLKS_PER_BIT  104    clk cycles per UART bit (12 MHz / 115200); min 8
//   IDLE_TIMEOUT  12000  clk cycles allowed between bytes inside a frame
// PORTS
//   clk          in   1   system clock; sole clock domain
//   rst          in   1   synchronous, active-high reset
//   rx           in   1   async UART input, idle high
//   tx           out  1   UART output, idle high (ack only, see CONFIGURATION)
//   leds         out  24  LED pattern; bit n drives led n
//   leds_strobe  out  1   1-cycle pulse on the cycle leds takes a new value
//   frame_err    out  1   1-cycle pulse on framing error or inter-byte timeout
// BEHAVIOUR
//   Reset: leds=0, leds_strobe=0, frame_err=0, tx=1, RX FSM IDLE, parser HUNT,
//     rx synchroniser flops = 1. Reset mid-byte/mid-frame discards all partial data.
//   Input: rx through 2-flop synchroniser; all sampling uses synchronised value.
//   RX FSM (bit counter 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT)):
//     IDLE  -> START on synchronised rx = 0.
//     START -> wait CLKS_PER_BIT/2 (integer division); rx still 0 -> DATA,
//              else glitch -> IDLE, no error.
//     DATA  -> 8 samples, each CLKS_PER_BIT after previous, LSB first -> STOP.
//     STOP  -> sample after CLKS_PER_BIT: 1 = byte_valid (1 cycle),
//              0 = framing error (frame_err pulse, parser -> HUNT);
//              either case -> IDLE immediately (no wait for stop-bit end).
//   Parser FSM: HUNT, B0, B1, B2.
//     HUNT: byte 0xA5 -> B0; any other byte ignored silently.
//     B0/B1/B2: byte stored to shadow[7:0]/[15:8]/[23:16]; 0xA5 is plain data.
//     B2 byte: leds <= {byte, shadow[15:0]}, leds_strobe=1 on next cycle edge
//       (leds and strobe change together, 1 cycle after byte_valid); -> HUNT.
//     leds never shows a partially updated pattern; shadow bits not visible.
//   Timeout: counter cleared on every byte_valid and in HUNT; in B0..B2 when it
//     reaches IDLE_TIMEOUT while RX FSM is IDLE -> frame_err pulse, -> HUNT,
//     shadow discarded, leds unchanged. Counter saturates, no wrap.
//   Simultaneous: byte_valid on the timeout cycle -> byte wins, no timeout.
//     Framing error and timeout never both pulse; framing error wins.
// CONFIGURATION
//   UART_ACK_EN defined: after each completed frame, transmit 0x06 8N1 on tx
//     (start, 8 data LSB first, 1 stop; each CLKS_PER_BIT cycles), start bit
//     begins the cycle after leds_strobe. A frame completing while an ack is
//     still in flight gets no second ack; the running ack is not disturbed.
//     frame_err never triggers a transmit.
//   UART_ACK_EN undefined: tx tied to 1; no TX logic synthesised.
// TESTING
//   CLKS_PER_BIT=16. Send A5 11 22 33 -> leds=0x332211, one strobe, 1 cycle
//     after last stop sample; no frame_err.
//   Send 00 7E A5 A5 FF 01 -> leds=0x01FFA5 (leading junk ignored, 2nd A5 = data).
//   A5 11 then byte 22 with stop bit=0 -> frame_err pulse; then A5 01 02 03 ->
//     leds=0x030201; leds unchanged in between.
//   A5 11 then silence > IDLE_TIMEOUT -> one frame_err, leds unchanged;
//     6-cycle rx low glitch in IDLE -> no byte, no error.
//   Assert rst mid-B1 -> leds=0, tx=1, next A5 AA BB CC -> leds=0xCCBBAA.
//   UART_ACK_EN: A5 01 02 03 -> tx emits 0x06 starting cycle after strobe,
//     10 bits x 16 cycles; undefined build -> tx stays 1 throughout.

Source files
------------

// File: rtl/uart_led_frame_rx.sv
// UART 8N1 receiver and 4-byte frame parser (0xA5 + 3 pattern bytes) driving a 24-LED register.
// Optional UART_ACK_EN: transmit 0x06 on tx after each completed frame; otherwise tx is tied high.
module uart_led_frame_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int IDLE_TIMEOUT = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [23:0] leds,
  output logic        leds_strobe,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_B0, P_B1, P_B2} p_state_t;

  // Handshake: byte_valid is a 1-cycle pulse with rx_byte stable in that cycle;
  // the parser has no back-pressure and must consume it immediately.
  logic            rx_meta, rx_s;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_byte;
  logic            byte_valid, stop_err;
  p_state_t        p_state, p_state_n;
  logic [15:0]     shadow;
  logic [TW-1:0]   to_cnt;
  logic            timeout_hit, frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_n;
  end

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_state_n = RX_START;
      RX_START: if (cnt == HALF_LAST) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (cnt == BIT_LAST) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  // Stop bit is judged at its centre; the FSM rearms without waiting for its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + 1'b1;
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            byte_valid <= rx_s;
            stop_err   <= !rx_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) p_state <= P_HUNT;
    else     p_state <= p_state_n;
  end

  // A byte or framing error in the same cycle pre-empts the timeout.
  always_comb begin
    timeout_hit = (p_state != P_HUNT) && (to_cnt == TO_LIMIT) &&
                  (rx_state == RX_IDLE) && !byte_valid && !stop_err;
    frame_done  = byte_valid && (p_state == P_B2);
    p_state_n   = p_state;
    if (stop_err) begin
      p_state_n = P_HUNT;
    end else if (byte_valid) begin
      case (p_state)
        P_HUNT:  if (rx_byte == 8'hA5) p_state_n = P_B0;
        P_B0:    p_state_n = P_B1;
        P_B1:    p_state_n = P_B2;
        default: p_state_n = P_HUNT;
      endcase
    end else if (timeout_hit) begin
      p_state_n = P_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds        <= '0;
      leds_strobe <= 1'b0;
      frame_err   <= 1'b0;
      shadow      <= '0;
      to_cnt      <= '0;
    end else begin
      leds_strobe <= frame_done;
      frame_err   <= stop_err | timeout_hit;
      if (frame_done) leds <= {rx_byte, shadow};
      if (byte_valid && p_state == P_B0) shadow[7:0]  <= rx_byte;
      if (byte_valid && p_state == P_B1) shadow[15:8] <= rx_byte;
      if (byte_valid || p_state == P_HUNT) to_cnt <= '0;
      else if (to_cnt != TO_LIMIT)         to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef UART_ACK_EN
  localparam logic [9:0] ACK_FRAME = {1'b1, 8'h06, 1'b0};
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_sh;

  // Strobes arriving while busy are dropped so a running ack is never restarted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (!tx_busy) begin
      if (leds_strobe) begin
        tx_busy <= 1'b1;
        tx      <= ACK_FRAME[0];
        tx_sh   <= ACK_FRAME;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 1'b1;
        tx     <= tx_sh[1];
        tx_sh  <= {1'b1, tx_sh[9:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_led_frame_rx.sv
// Randomized and directed bench for uart_led_frame_rx with a byte-level frame model and event scoreboard.
module tb_uart_led_frame_rx;
  localparam int CPB = 16;
  localparam int TO  = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [23:0] leds;
  logic        leds_strobe;
  logic        frame_err;

  uart_led_frame_rx #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .leds(leds), .leds_strobe(leds_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int spurious = 0;
  int tx_bad = 0;

  // Expected output events: bit 24 set = frame_err, else a strobe with leds in [23:0].
  logic [24:0] exp_q[$];
  int          phase = 0;
  logic [15:0] sh;
  logic [23:0] model_leds = '0;
  logic [23:0] prev_leds = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Frame rules at byte granularity: hunt for 0xA5, then collect three pattern bytes.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back({1'b1, 24'h0});
      phase = 0;
    end else if (phase == 0) begin
      if (b == 8'hA5) phase = 1;
    end else if (phase == 1) begin
      sh[7:0] = b; phase = 2;
    end else if (phase == 2) begin
      sh[15:8] = b; phase = 3;
    end else begin
      model_leds = {b, sh};
      exp_q.push_back({1'b0, model_leds});
      phase = 0;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok = 1'b1);
    model_byte(b, ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst && (leds_strobe || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {7'd0, frame_err, leds_strobe ? leds : 24'h0}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check(e[24] ? "frame_err_event" : "strobe_event",
              {6'd0, leds_strobe, frame_err, frame_err ? 24'h0 : leds},
              {6'd0, !e[24], e[24], e[23:0]});
      end
    end
    if (!rst && !leds_strobe && leds !== prev_leds) spurious++;
    prev_leds = leds;
  end

`ifdef UART_ACK_EN
  localparam logic [9:0] ACK_BITS = {1'b1, 8'h06, 1'b0};
  always @(negedge clk) begin
    if (!rst && leds_strobe) begin
      check("ack_idle_at_strobe", {31'd0, tx}, 32'd1);
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? 1 + CPB / 2 : CPB) @(negedge clk);
        check("ack_bit", {31'd0, tx}, {31'd0, ACK_BITS[k]});
      end
    end
  end
`else
  always @(negedge clk) if (tx !== 1'b1) tx_bad++;
`endif

  initial begin
    logic [7:0] b;
    bit ok;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_leds", {8'd0, leds}, 32'h0);
    check("reset_strobe", {31'd0, leds_strobe}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    idle(20);

    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(50);
    check("basic_frame", {8'd0, leds}, 32'h332211);

    send_byte(8'h00); send_byte(8'h7E); send_byte(8'hA5);
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h01);
    idle(50);
    check("junk_and_a5_data", {8'd0, leds}, 32'h01FFA5);

    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22, 1'b0);
    idle(200);
    check("leds_after_stop_err", {8'd0, leds}, 32'h01FFA5);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(50);
    check("frame_after_err", {8'd0, leds}, 32'h030201);

    send_byte(8'hA5); send_byte(8'h11);
    exp_q.push_back({1'b1, 24'h0});
    phase = 0;
    idle(TO + 200);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    idle(100);
    check("leds_after_timeout_glitch", {8'd0, leds}, 32'h030201);

    send_byte(8'hA5); send_byte(8'h11);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_frame_reset_leds", {8'd0, leds}, 32'h0);
    check("mid_frame_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_frame_reset_queue", exp_q.size(), 32'd0);
    phase = 0;
    model_leds = '0;
    rst = 1'b0;
    idle(20);
    send_byte(8'hA5); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(50);
    check("frame_after_reset", {8'd0, leds}, 32'hCCBBAA);

    for (int n = 0; n < 80; n++) begin
      b  = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      send_byte(b, ok);
      idle(ok ? $urandom_range(0, 40) : 200);
    end
    idle(CPB * 12);

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_leds", {8'd0, leds}, {8'd0, model_leds});
    check("no_unstrobed_leds_change", spurious, 32'd0);
    check("tx_held_high", tx_bad, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
